// File: rtl/proc_param_pkg.sv
// Shared encodings for the parametrised multicycle core: opcodes, step
// counter states and the ALU operation select.
package proc_param_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    localparam logic [3:0] OP_MV   = 4'b0000;
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MVNZ = 4'b1000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_e;

    // ALU instructions occupy the contiguous block add..slt.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

    function automatic alu_op_e alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/registrador.sv
// Load-enabled register with asynchronous active-low clear; used for IR,
// the register file, A and G.
module registrador #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/unidade_controle_param.sv
// Control unit: T0..T3 step counter plus combinational decode of step and IR
// into one-hot bus enables, register loads, ALU select and Done.
module unidade_controle_param
    import proc_param_pkg::*;
#(
    parameter  int NREGS  = 8,
    localparam int RSEL_W = $clog2(NREGS),
    localparam int IR_W   = 4 + 2 * RSEL_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic [IR_W-1:0]  ir_i,
    input  logic             g_nz_i,
    output logic             ir_in_o,
    output logic [NREGS-1:0] r_in_o,
    output logic [NREGS-1:0] r_out_o,
    output logic             a_in_o,
    output logic             g_in_o,
    output logic             g_out_o,
    output logic             din_out_o,
    output alu_op_e          ula_op_o,
    output logic             done_o
);

    step_e step_q, step_d;

    logic [3:0]        opcode;
    logic [RSEL_W-1:0] rx;
    logic [RSEL_W-1:0] ry;

    assign opcode = ir_i[IR_W-1 -: 4];
    assign rx     = ir_i[2*RSEL_W-1 -: RSEL_W];
    assign ry     = ir_i[RSEL_W-1:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ir_in_o   = 1'b0;
        r_in_o    = '0;
        r_out_o   = '0;
        a_in_o    = 1'b0;
        g_in_o    = 1'b0;
        g_out_o   = 1'b0;
        din_out_o = 1'b0;
        ula_op_o  = ALU_ADD;
        done_o    = 1'b0;

        unique case (step_q)
            T0: ir_in_o = run_i;
            T1: begin
                if (is_alu_op(opcode)) begin
                    r_out_o[rx] = 1'b1;
                    a_in_o      = 1'b1;
                end else begin
                    done_o = 1'b1;
                    case (opcode)
                        OP_MV: begin
                            r_out_o[ry] = 1'b1;
                            r_in_o[rx]  = 1'b1;
                        end
                        OP_MVI: begin
                            din_out_o  = 1'b1;
                            r_in_o[rx] = 1'b1;
                        end
                        OP_MVNZ: begin
                            r_out_o[ry] = 1'b1;
                            r_in_o[rx]  = g_nz_i;
                        end
                        default: ;
                    endcase
                end
            end
            T2: begin
                r_out_o[ry] = 1'b1;
                g_in_o      = 1'b1;
                ula_op_o    = alu_op_of(opcode);
            end
            T3: begin
                g_out_o    = 1'b1;
                r_in_o[rx] = 1'b1;
                done_o     = 1'b1;
            end
        endcase
    end

    // T0 waits for Run; the final step of any instruction returns to T0.
    always_comb begin
        step_d = step_q;
        if (done_o) begin
            step_d = T0;
        end else if (step_q != T0) begin
            step_d = step_e'(step_q + 2'd1);
        end else if (run_i) begin
            step_d = T1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle processor: register file, A/G ALU registers and a
// single one-hot shared bus, sequenced by unidade_controle_param.
module processador_multiciclo_param
    import proc_param_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 8,
    localparam int RSEL_W = $clog2(NREGS),
    localparam int IR_W   = 4 + 2 * RSEL_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    output logic [DATA_W-1:0] Rx_data,
    output logic [DATA_W-1:0] Ry_data
);

    logic [IR_W-1:0]   ir_q;
    logic [DATA_W-1:0] r_q [NREGS];
    logic [DATA_W-1:0] a_q, g_q, alu_res;

    logic              ir_in, a_in, g_in, g_out, din_out;
    logic [NREGS-1:0]  r_in, r_out;
    alu_op_e           ula_op;

    unidade_controle_param #(
        .NREGS(NREGS)
    ) u_ctrl (
        .clk_i    (Clock),
        .rst_n_i  (Resetn),
        .run_i    (Run),
        .ir_i     (ir_q),
        .g_nz_i   (|g_q),
        .ir_in_o  (ir_in),
        .r_in_o   (r_in),
        .r_out_o  (r_out),
        .a_in_o   (a_in),
        .g_in_o   (g_in),
        .g_out_o  (g_out),
        .din_out_o(din_out),
        .ula_op_o (ula_op),
        .done_o   (Done)
    );

    // The instruction word sits in the low bits of DIN; a narrow bus is zero-extended.
    registrador #(.W(IR_W)) u_ir (
        .clk_i(Clock), .rst_n_i(Resetn), .en_i(ir_in), .d_i(IR_W'(DIN)), .q_o(ir_q)
    );

    // NOTE: the register file is built from resettable registers because reset must leave every Rk at zero.
    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        registrador #(.W(DATA_W)) u_r (
            .clk_i(Clock), .rst_n_i(Resetn), .en_i(r_in[k]), .d_i(BusWires), .q_o(r_q[k])
        );
    end

    registrador #(.W(DATA_W)) u_a (
        .clk_i(Clock), .rst_n_i(Resetn), .en_i(a_in), .d_i(BusWires), .q_o(a_q)
    );

    registrador #(.W(DATA_W)) u_g (
        .clk_i(Clock), .rst_n_i(Resetn), .en_i(g_in), .d_i(alu_res), .q_o(g_q)
    );

    always_comb begin
        alu_res = '0;
        case (ula_op)
            ALU_ADD: alu_res = a_q + BusWires;
            ALU_SUB: alu_res = a_q - BusWires;
            ALU_AND: alu_res = a_q & BusWires;
            ALU_OR:  alu_res = a_q | BusWires;
            ALU_XOR: alu_res = a_q ^ BusWires;
            ALU_SLT: alu_res[0] = $signed(a_q) < $signed(BusWires);
            default: alu_res = '0;
        endcase
    end

    // The controller enables at most one source, so OR-ing gated sources is the mux.
    always_comb begin
        BusWires = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (r_out[k]) BusWires |= r_q[k];
        end
        if (g_out)   BusWires |= g_q;
        if (din_out) BusWires |= DIN;
    end

    assign Rx_data = r_q[ir_q[2*RSEL_W-1 -: RSEL_W]];
    assign Ry_data = r_q[ir_q[RSEL_W-1:0]];

endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Directed bench for processador_multiciclo_param: a 16-bit/8-register core,
// an 8-bit/4-register core and a 16-bit/16-register core on one clock.
module tb_processador_multiciclo_param;

    logic        Clock;
    logic        Resetn;

    logic        run_a, done_a;
    logic [15:0] din_a, bus_a, rx_a, ry_a;
    logic        run_b, done_b;
    logic [7:0]  din_b, bus_b, rx_b, ry_b;
    logic        run_c, done_c;
    logic [15:0] din_c, bus_c, rx_c, ry_c;

    int          checks = 0;
    int          errors = 0;
    int          last_cyc;
    logic [31:0] last_bus;

    processador_multiciclo_param #(.DATA_W(16), .NREGS(8)) u_dut_a (
        .Clock(Clock), .Resetn(Resetn), .Run(run_a), .DIN(din_a),
        .Done(done_a), .BusWires(bus_a), .Rx_data(rx_a), .Ry_data(ry_a)
    );

    processador_multiciclo_param #(.DATA_W(8), .NREGS(4)) u_dut_b (
        .Clock(Clock), .Resetn(Resetn), .Run(run_b), .DIN(din_b),
        .Done(done_b), .BusWires(bus_b), .Rx_data(rx_b), .Ry_data(ry_b)
    );

    processador_multiciclo_param #(.DATA_W(16), .NREGS(16)) u_dut_c (
        .Clock(Clock), .Resetn(Resetn), .Run(run_c), .DIN(din_c),
        .Done(done_c), .BusWires(bus_c), .Rx_data(rx_c), .Ry_data(ry_c)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction word: opcode, Rx, Ry, with field widths set by each core's NREGS.
    function automatic logic [31:0] enc(input int w, input logic [3:0] op, input int rx, input int ry);
        case (w)
            0:       return {22'd0, op, rx[2:0], ry[2:0]};
            1:       return {24'd0, op, rx[1:0], ry[1:0]};
            default: return {20'd0, op, rx[3:0], ry[3:0]};
        endcase
    endfunction

    task automatic set_in(input int w, input logic r, input logic [31:0] d);
        case (w)
            0:       begin run_a = r; din_a = d[15:0]; end
            1:       begin run_b = r; din_b = d[7:0];  end
            default: begin run_c = r; din_c = d[15:0]; end
        endcase
    endtask

    function automatic logic done_of(input int w);
        return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
    endfunction

    function automatic logic [31:0] bus_of(input int w);
        return (w == 0) ? {16'd0, bus_a} : (w == 1) ? {24'd0, bus_b} : {16'd0, bus_c};
    endfunction

    function automatic logic [31:0] rx_of(input int w);
        return (w == 0) ? {16'd0, rx_a} : (w == 1) ? {24'd0, rx_b} : {16'd0, rx_c};
    endfunction

    function automatic logic [31:0] ry_of(input int w);
        return (w == 0) ? {16'd0, ry_a} : (w == 1) ? {24'd0, ry_b} : {16'd0, ry_c};
    endfunction

    // Fetch in T0, then run until Done (at most 7 further cycles). last_cyc is
    // the cycle, counting T0 as 1, in which Done was seen (0 if never).
    task automatic exec(input int w, input logic [3:0] op, input int rx, input int ry,
                        input logic [31:0] imm);
        int cyc;
        bit seen;
        @(negedge Clock);
        set_in(w, 1'b1, enc(w, op, rx, ry));
        cyc  = 1;
        seen = 1'b0;
        last_bus = 'x;
        while (!seen && cyc < 8) begin
            @(negedge Clock);
            cyc++;
            set_in(w, 1'b0, imm);
            #1;
            if (done_of(w)) begin
                seen     = 1'b1;
                last_bus = bus_of(w);
            end
        end
        last_cyc = seen ? cyc : 0;
        @(negedge Clock);
        #1;
    endtask

    task automatic run_chk(input int w, input logic [3:0] op, input int rx, input int ry,
                           input logic [31:0] imm, input int ecyc, input logic [31:0] erx,
                           input string tag);
        exec(w, op, rx, ry, imm);
        chk({tag, "_cycles"}, last_cyc, ecyc);
        chk({tag, "_rx"}, rx_of(w), erx);
    endtask

    initial begin
        Resetn = 1'b0;
        set_in(0, 1'b0, 0);
        set_in(1, 1'b0, 0);
        set_in(2, 1'b0, 0);
        repeat (3) @(negedge Clock);
        #1;
        chk("reset_done", done_a, 0);
        chk("reset_bus", bus_a, 0);
        chk("reset_rx", rx_a, 0);
        chk("reset_ry", ry_a, 0);
        @(negedge Clock);
        Resetn = 1'b1;

        // mvi / sub with wrap-around
        run_chk(0, 4'b0001, 0, 0, 32'h5, 2, 32'h5, "mvi_r0");
        chk("mvi_r0_bus", last_bus, 32'h5);
        run_chk(0, 4'b0001, 1, 0, 32'h3, 2, 32'h3, "mvi_r1");
        run_chk(0, 4'b0011, 0, 1, 32'h0, 4, 32'h2, "sub_r0_r1");
        chk("sub_r0_r1_bus", last_bus, 32'h2);
        run_chk(0, 4'b0011, 1, 0, 32'h0, 4, 32'h1, "sub_r1_r0");
        run_chk(0, 4'b0011, 1, 0, 32'h0, 4, 32'hFFFF, "sub_wrap");

        // signed set-less-than
        run_chk(0, 4'b0001, 2, 0, 32'hFFFF, 2, 32'hFFFF, "mvi_r2");
        run_chk(0, 4'b0001, 3, 0, 32'h1, 2, 32'h1, "mvi_r3");
        run_chk(0, 4'b0111, 2, 3, 32'h0, 4, 32'h1, "slt_neg_lt_pos");
        run_chk(0, 4'b0001, 2, 0, 32'hFFFF, 2, 32'hFFFF, "mvi_r2_again");
        run_chk(0, 4'b0111, 3, 2, 32'h0, 4, 32'h0, "slt_pos_lt_neg");

        // bitwise ops, Rx==Ry, mv
        run_chk(0, 4'b0001, 0, 0, 32'h0FF0, 2, 32'h0FF0, "mvi_r0_mask");
        run_chk(0, 4'b0001, 1, 0, 32'h3C3C, 2, 32'h3C3C, "mvi_r1_pat");
        run_chk(0, 4'b0100, 0, 1, 32'h0, 4, 32'h0C30, "and");
        run_chk(0, 4'b0001, 0, 0, 32'h0FF0, 2, 32'h0FF0, "mvi_r0_or");
        run_chk(0, 4'b0101, 0, 1, 32'h0, 4, 32'h3FFC, "or");
        run_chk(0, 4'b0001, 0, 0, 32'h0FF0, 2, 32'h0FF0, "mvi_r0_xor");
        run_chk(0, 4'b0110, 0, 1, 32'h0, 4, 32'h33CC, "xor");
        run_chk(0, 4'b0010, 1, 1, 32'h0, 4, 32'h7878, "add_self");
        run_chk(0, 4'b0000, 7, 1, 32'h0, 2, 32'h7878, "mv_r7_r1");
        chk("mv_bus", last_bus, 32'h7878);

        // mvnz gated by the retained G
        run_chk(0, 4'b0001, 4, 0, 32'h9, 2, 32'h9, "mvi_r4");
        run_chk(0, 4'b0001, 5, 0, 32'h9, 2, 32'h9, "mvi_r5");
        run_chk(0, 4'b0011, 4, 5, 32'h0, 4, 32'h0, "sub_to_zero");
        run_chk(0, 4'b0001, 6, 0, 32'h55, 2, 32'h55, "mvi_r6");
        run_chk(0, 4'b1000, 6, 5, 32'h0, 2, 32'h55, "mvnz_g_zero");
        run_chk(0, 4'b0001, 4, 0, 32'h3, 2, 32'h3, "mvi_r4_3");
        run_chk(0, 4'b0001, 5, 0, 32'h4, 2, 32'h4, "mvi_r5_4");
        run_chk(0, 4'b0010, 4, 5, 32'h0, 4, 32'h7, "add_to_7");
        run_chk(0, 4'b0001, 0, 0, 32'h0, 2, 32'h0, "mvi_between");
        run_chk(0, 4'b1000, 6, 5, 32'h0, 2, 32'h4, "mvnz_g_nonzero");

        // nop: two cycles, bus idle, no writes
        run_chk(0, 4'b1001, 6, 4, 32'h0, 2, 32'h4, "nop_1001");
        chk("nop_bus", last_bus, 32'h0);
        chk("nop_ry", ry_a, 32'h7);

        // Run low in T0: nothing fetched
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            set_in(0, 1'b0, enc(0, 4'b0010, 1, 2));
            #1;
            chk("idle_done", done_a, 0);
            chk("idle_ir_rx", rx_a, 32'h4);
        end
        run_chk(0, 4'b0001, 7, 0, 32'h1234, 2, 32'h1234, "mvi_after_idle");

        // Reset asserted in T2 of an add
        @(negedge Clock);
        set_in(0, 1'b1, enc(0, 4'b0010, 1, 7));
        @(negedge Clock);
        set_in(0, 1'b0, 0);
        @(negedge Clock);
        #1;
        chk("t2_bus_ry", bus_a, 32'h1234);
        Resetn = 1'b0;
        #1;
        chk("midreset_done", done_a, 0);
        chk("midreset_bus", bus_a, 0);
        chk("midreset_rx", rx_a, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exec(0, 4'b1111, 0, k, 32'h0);
            chk("postreset_cycles", last_cyc, 2);
            chk("postreset_reg", ry_a, 0);
        end
        run_chk(0, 4'b0001, 2, 0, 32'h5, 2, 32'h5, "postreset_mvi");
        run_chk(0, 4'b1000, 3, 2, 32'h0, 2, 32'h0, "postreset_mvnz_g0");

        // 8-bit core: signed compare across 0x80 and modulo-256 add
        run_chk(1, 4'b0001, 2, 0, 32'h80, 2, 32'h80, "w8_mvi_r2");
        run_chk(1, 4'b0001, 3, 0, 32'h7F, 2, 32'h7F, "w8_mvi_r3");
        run_chk(1, 4'b0111, 2, 3, 32'h0, 4, 32'h1, "w8_slt");
        run_chk(1, 4'b0001, 0, 0, 32'hFF, 2, 32'hFF, "w8_mvi_r0");
        run_chk(1, 4'b0001, 1, 0, 32'h02, 2, 32'h02, "w8_mvi_r1");
        run_chk(1, 4'b0010, 0, 1, 32'h0, 4, 32'h01, "w8_add_wrap");

        // 16-register core: top register, mv, opcode 1111 as nop
        run_chk(2, 4'b0001, 15, 0, 32'hA, 2, 32'hA, "r16_mvi_r15");
        run_chk(2, 4'b0000, 9, 15, 32'h0, 2, 32'hA, "r16_mv_r9");
        run_chk(2, 4'b1111, 9, 15, 32'h0, 2, 32'hA, "r16_nop");
        chk("r16_nop_bus", last_bus, 32'h0);
        chk("r16_nop_ry", ry_c, 32'hA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
